// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//   Program counter and byte-serial instruction fetcher for an 8-bit, 64K
//   program RAM. It drives the RAM address, samples the combinational read
//   data, assembles 1- or 2-byte instructions and hands each one to the
//   decoder over a valid/ready handshake. Fetch stops permanently on the
//   halt opcode; only reset leaves the halted state.
//
// Parameters
//   RESET_PC     PC loaded on reset
//   HALT_OPCODE  opcode that halts fetch (never forwarded to the decoder)
//
// Ports
//   clk             in   1   system clock, rising edge
//   rst_n           in   1   asynchronous active-low reset
//   run             in   1   fetch enable (stalls FETCH_OP/FETCH_ARG when 0)
//   mem_addr        out  16  RAM byte address (= pc)
//   mem_data        in   8   RAM read data, valid in the same cycle
//   redirect_valid  in   1   branch/jump request from execute
//   redirect_addr   in   16  new PC when redirect_valid=1
//   instr_valid     out  1   instruction outputs valid
//   instr_ready     in   1   decoder accepts instruction
//   instr_opcode    out  8   opcode byte
//   instr_operand   out  8   operand byte (0 for 1-byte instructions)
//   instr_len       out  1   0 = 1-byte, 1 = 2-byte
//   instr_pc        out  16  address of the opcode byte
//   instr_count     out  16  accepted-instruction counter (wraps)
//   halted          out  1   sticky halt flag
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [7:0]  HALT_OPCODE = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_data,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_addr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  instr_opcode,
  output logic [7:0]  instr_operand,
  output logic        instr_len,
  output logic [15:0] instr_pc,
  output logic [15:0] instr_count,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_FETCH_OP  = 2'd0,
    S_FETCH_ARG = 2'd1,
    S_HOLD      = 2'd2,
    S_HALT      = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  operand_q, operand_d;
  logic        len_q, len_d;
  logic [15:0] ipc_q, ipc_d;
  logic [15:0] count_q, count_d;

  logic        is_halt_op;
  assign is_halt_op = (mem_data == HALT_OPCODE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH_OP;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; redirect outranks both run and instr_ready
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH_OP: begin
        if (redirect_valid) begin
          state_d = S_FETCH_OP;
        end else if (run) begin
          if (is_halt_op)        state_d = S_HALT;
          else if (!mem_data[7]) state_d = S_FETCH_ARG;
          else                   state_d = S_HOLD;
        end
      end
      S_FETCH_ARG: begin
        if (redirect_valid)      state_d = S_FETCH_OP;
        else if (run)            state_d = S_HOLD;
      end
      S_HOLD: begin
        if (redirect_valid || instr_ready) state_d = S_FETCH_OP;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: state_d = S_FETCH_OP;
    endcase
  end

  // Output logic
  always_comb begin
    instr_valid = (state_q == S_HOLD);
    halted      = (state_q == S_HALT);
  end

  assign mem_addr      = pc_q;
  assign instr_opcode  = opcode_q;
  assign instr_operand = operand_q;
  assign instr_len     = len_q;
  assign instr_pc      = ipc_q;
  assign instr_count   = count_q;

  // Datapath next values
  always_comb begin
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    len_d     = len_q;
    ipc_d     = ipc_q;
    count_d   = count_q;
    unique case (state_q)
      S_FETCH_OP: begin
        if (redirect_valid) begin
          pc_d = redirect_addr;
        end else if (run) begin
          pc_d = pc_q + 16'd1;
          // The halt byte is consumed but never shown on instr_*; the
          // outputs keep the last real instruction.
          if (!is_halt_op) begin
            opcode_d = mem_data;
            ipc_d    = pc_q;
            len_d    = ~mem_data[7];
            if (mem_data[7]) operand_d = 8'h00;
          end
        end
      end
      S_FETCH_ARG: begin
        if (redirect_valid) begin
          pc_d = redirect_addr;
        end else if (run) begin
          operand_d = mem_data;
          pc_d      = pc_q + 16'd1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d = redirect_addr;
        end else if (instr_ready) begin
          count_d = count_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      opcode_q  <= 8'h00;
      operand_q <= 8'h00;
      len_q     <= 1'b0;
      ipc_q     <= 16'h0000;
      count_q   <= 16'h0000;
    end else begin
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      len_q     <= len_d;
      ipc_q     <= ipc_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // DUT0: RESET_PC = 0000
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_addr = 16'h0000;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [7:0]  instr_opcode;
  logic [7:0]  instr_operand;
  logic        instr_len;
  logic [15:0] instr_pc;
  logic [15:0] instr_count;
  logic        halted;

  // DUT1: RESET_PC = FFFF
  logic        rst_n1 = 1'b0;
  logic [15:0] mem_addr1;
  logic [7:0]  mem_data1;
  logic        instr_valid1;
  logic [7:0]  instr_opcode1;
  logic [7:0]  instr_operand1;
  logic        instr_len1;
  logic [15:0] instr_pc1;
  logic [15:0] instr_count1;
  logic        halted1;

  logic [7:0] mem0 [0:65535];
  logic [7:0] mem1 [0:65535];
  assign mem_data  = mem0[mem_addr];
  assign mem_data1 = mem1[mem_addr1];

  instr_fetch_unit #(.RESET_PC(16'h0000), .HALT_OPCODE(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mem_addr(mem_addr), .mem_data(mem_data),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_operand(instr_operand),
    .instr_len(instr_len), .instr_pc(instr_pc), .instr_count(instr_count),
    .halted(halted)
  );

  instr_fetch_unit #(.RESET_PC(16'hFFFF), .HALT_OPCODE(8'hFF)) dut1 (
    .clk(clk), .rst_n(rst_n1), .run(1'b1), .mem_addr(mem_addr1), .mem_data(mem_data1),
    .redirect_valid(1'b0), .redirect_addr(16'h0000),
    .instr_valid(instr_valid1), .instr_ready(1'b0),
    .instr_opcode(instr_opcode1), .instr_operand(instr_operand1),
    .instr_len(instr_len1), .instr_pc(instr_pc1), .instr_count(instr_count1),
    .halted(halted1)
  );

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  arg;
    logic        len;
    logic [15:0] pc;
  } vec_t;

  vec_t vecs [5];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int k;
    for (k = 0; k < 50; k++) begin
      if (instr_valid === 1'b1) break;
      step();
    end
    if (k == 50) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_halted();
    int k;
    for (k = 0; k < 50; k++) begin
      if (halted === 1'b1) break;
      step();
    end
    if (k == 50) check("halt_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    check("rst_valid",  {31'd0, instr_valid}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_count",  {16'd0, instr_count}, 32'd0);
    check("rst_addr",   {16'd0, mem_addr}, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic check_instr(input string name, input vec_t v);
    check({name, "_op"},  {24'd0, instr_opcode}, {24'd0, v.op});
    check({name, "_arg"}, {24'd0, instr_operand}, {24'd0, v.arg});
    check({name, "_len"}, {31'd0, instr_len}, {31'd0, v.len});
    check({name, "_pc"},  {16'd0, instr_pc}, {16'd0, v.pc});
  endtask

  initial begin
    vec_t v;
    for (int a = 0; a < 65536; a++) begin
      mem0[a] = 8'h80;
      mem1[a] = 8'h80;
    end
    mem0[0] = 8'h00; mem0[1] = 8'h02; mem0[2] = 8'h80; mem0[3] = 8'h01;
    mem0[4] = 8'h02; mem0[5] = 8'h81; mem0[6] = 8'hC0; mem0[7] = 8'hFF;
    mem0[16'h0010] = 8'h85;
    mem1[16'hFFFF] = 8'h05;
    mem1[16'h0000] = 8'hAA;

    vecs[0] = '{op: 8'h00, arg: 8'h02, len: 1'b1, pc: 16'h0000};
    vecs[1] = '{op: 8'h80, arg: 8'h00, len: 1'b0, pc: 16'h0002};
    vecs[2] = '{op: 8'h01, arg: 8'h02, len: 1'b1, pc: 16'h0003};
    vecs[3] = '{op: 8'h81, arg: 8'h00, len: 1'b0, pc: 16'h0005};
    vecs[4] = '{op: 8'hC0, arg: 8'h00, len: 1'b0, pc: 16'h0006};

    // --- Main program, ready=1 ---
    do_reset();
    run = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_valid($sformatf("prog%0d", i));
      check_instr($sformatf("prog%0d", i), vecs[i]);
      check($sformatf("prog%0d_count", i), {16'd0, instr_count}, i);
      step();
    end
    wait_halted();
    check("halt_flag",   {31'd0, halted}, 32'd1);
    check("halt_valid",  {31'd0, instr_valid}, 32'd0);
    check("halt_count",  {16'd0, instr_count}, 32'd5);
    check("halt_pc",     {16'd0, mem_addr}, 32'h8);
    check("halt_hidden", {24'd0, instr_opcode}, 32'hC0);

    // --- Redirect while halted is ignored ---
    redirect_valid = 1'b1;
    redirect_addr  = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      step();
      check("halt_redir_flag", {31'd0, halted}, 32'd1);
      check("halt_redir_pc",   {16'd0, mem_addr}, 32'h8);
    end
    redirect_valid = 1'b0;

    // --- Asynchronous reset while halted ---
    rst_n = 1'b0;
    #1;
    check("rst_in_halt_flag", {31'd0, halted}, 32'd0);
    check("rst_in_halt_pc",   {16'd0, mem_addr}, 32'd0);
    check("rst_in_halt_cnt",  {16'd0, instr_count}, 32'd0);
    step();
    rst_n = 1'b1;
    wait_valid("refetch_halt");
    check_instr("refetch_halt", vecs[0]);
    step();

    // --- Backpressure: ready=0 for 10 cycles ---
    do_reset();
    instr_ready = 1'b0;
    wait_valid("stall");
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_op_pc", {instr_opcode, instr_operand, instr_pc}, {8'h00, 8'h02, 16'h0000});
      check("stall_addr",  {16'd0, mem_addr}, 32'h2);
    end
    check("stall_count", {16'd0, instr_count}, 32'd0);
    instr_ready = 1'b1;
    step();
    check("stall_release_cnt", {16'd0, instr_count}, 32'd1);
    check("stall_release_vld", {31'd0, instr_valid}, 32'd0);

    // --- Reset mid-HOLD ---
    wait_valid("hold1");
    instr_ready = 1'b0;
    check_instr("hold1", vecs[1]);
    step();
    rst_n = 1'b0;
    #1;
    check("rst_hold_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_hold_count", {16'd0, instr_count}, 32'd0);
    check("rst_hold_addr",  {16'd0, mem_addr}, 32'd0);
    check("rst_hold_op",    {24'd0, instr_opcode}, 32'd0);
    step();
    rst_n = 1'b1;
    instr_ready = 1'b1;
    wait_valid("refetch_hold");
    check_instr("refetch_hold", vecs[0]);

    // --- Redirect during FETCH_ARG ---
    do_reset();
    step();  // opcode 00 sampled, now in FETCH_ARG
    check("fa_addr", {16'd0, mem_addr}, 32'h1);
    redirect_valid = 1'b1;
    redirect_addr  = 16'h0010;
    step();
    redirect_valid = 1'b0;
    check("redir_addr",  {16'd0, mem_addr}, 32'h10);
    check("redir_valid", {31'd0, instr_valid}, 32'd0);
    wait_valid("redir");
    v = '{op: 8'h85, arg: 8'h00, len: 1'b0, pc: 16'h0010};
    check_instr("redir", v);
    check("redir_count", {16'd0, instr_count}, 32'd0);
    step();
    check("redir_accept_cnt", {16'd0, instr_count}, 32'd1);

    // --- run=0 in FETCH_OP ---
    run = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      check("norun_addr",  {16'd0, mem_addr}, 32'd0);
      check("norun_valid", {31'd0, instr_valid}, 32'd0);
    end
    run = 1'b1;
    wait_valid("run_resume");
    check_instr("run_resume", vecs[0]);

    // --- PC wrap, RESET_PC=FFFF ---
    rst_n1 = 1'b1;
    begin
      int k;
      for (k = 0; k < 20; k++) begin
        if (instr_valid1 === 1'b1) break;
        step();
      end
      if (k == 20) check("wrap_timeout", 32'd0, 32'd1);
    end
    check("wrap_op",   {24'd0, instr_opcode1}, 32'h05);
    check("wrap_arg",  {24'd0, instr_operand1}, 32'hAA);
    check("wrap_len",  {31'd0, instr_len1}, 32'd1);
    check("wrap_pc",   {16'd0, instr_pc1}, 32'hFFFF);
    check("wrap_addr", {16'd0, mem_addr1}, 32'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
